// File: rtl/pq_pkg.sv
// Shared definitions for the binary-heap priority queue.
// Only the controller state lives here; key/value widths are per-instance.
package pq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SIFT_UP,
        SIFT_DOWN
    } pq_state_e;

endpackage

// File: rtl/heap_cmp.sv
// Strict "better than" test between two keys: a smaller key ranks first in a
// min-queue, a larger key in a max-queue. Equal keys are never better.
module heap_cmp #(
    parameter int KEY_W     = 8,
    parameter int MAX_FIRST = 0
) (
    input  logic [KEY_W-1:0] a_key_i,
    input  logic [KEY_W-1:0] b_key_i,
    output logic             better_o
);

    assign better_o = (MAX_FIRST != 0) ? (a_key_i > b_key_i) : (a_key_i < b_key_i);

endmodule

// File: rtl/heap_pq_param.sv
// Binary-heap priority queue: one compare/swap per cycle while sifting,
// with the top item always presented on kvo_key/kvo_val.
module heap_pq_param
    import pq_pkg::*;
#(
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8,
    parameter int LEVELS    = 3,
    parameter int MAX_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic              deq,
    input  logic [KEY_W-1:0]  kvi_key,
    input  logic [VAL_W-1:0]  kvi_val,
    output logic [KEY_W-1:0]  kvo_key,
    output logic [VAL_W-1:0]  kvo_val,
    output logic              kvo_valid,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic [LEVELS-1:0] count
);

    localparam int DEPTH = (1 << LEVELS) - 1;

    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [VAL_W-1:0]  val_t;
    typedef logic [LEVELS-1:0] idx_t;
    typedef logic [LEVELS:0]   widx_t;

    localparam idx_t ROOT = idx_t'(1);

    key_t      heap_key_q [1:DEPTH];
    val_t      heap_val_q [1:DEPTH];
    pq_state_e state_q, state_d;
    idx_t      count_q, count_d;
    idx_t      idx_q, idx_d;

    logic      full_w, empty_w;
    widx_t     left_w, right_w, cnt_w, grand_w;
    logic      left_ok, right_ok, grand_ok;
    idx_t      left_idx, right_idx, child_idx, parent_idx;
    idx_t      cand_idx, node_idx, ins_idx;
    logic      right_better, pick_right, cand_better;
    logic      do_ins, do_rem, do_rep, do_swap;

    assign full_w  = (count_q == idx_t'(DEPTH));
    assign empty_w = (count_q == '0);
    assign ins_idx = count_q + ROOT;

    // Child indices are formed one bit wider so 2i never wraps; a node
    // exists only if its index does not exceed the current count.
    assign cnt_w     = {1'b0, count_q};
    assign left_w    = {idx_q, 1'b0};
    assign right_w   = {idx_q, 1'b1};
    assign left_ok   = (left_w <= cnt_w);
    assign right_ok  = (right_w <= cnt_w);
    assign left_idx  = left_ok  ? left_w[LEVELS-1:0]  : ROOT;
    assign right_idx = right_ok ? right_w[LEVELS-1:0] : ROOT;

    heap_cmp #(.KEY_W(KEY_W), .MAX_FIRST(MAX_FIRST)) u_cmp_child (
        .a_key_i  (heap_key_q[right_idx]),
        .b_key_i  (heap_key_q[left_idx]),
        .better_o (right_better)
    );

    assign pick_right = right_ok & right_better;
    assign child_idx  = pick_right ? right_idx : left_idx;
    assign grand_w    = {child_idx, 1'b0};
    assign grand_ok   = (grand_w <= cnt_w);
    assign parent_idx = (idx_q > ROOT) ? (idx_q >> 1) : ROOT;

    // Sift-up compares the node against its parent; sift-down compares the
    // chosen child against the node. Both swap cand_idx with node_idx.
    assign cand_idx = (state_q == SIFT_UP) ? idx_q      : child_idx;
    assign node_idx = (state_q == SIFT_UP) ? parent_idx : idx_q;

    heap_cmp #(.KEY_W(KEY_W), .MAX_FIRST(MAX_FIRST)) u_cmp_node (
        .a_key_i  (heap_key_q[cand_idx]),
        .b_key_i  (heap_key_q[node_idx]),
        .better_o (cand_better)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        do_ins  = 1'b0;
        do_rem  = 1'b0;
        do_rep  = 1'b0;
        do_swap = 1'b0;
        case (state_q)
            IDLE: begin
                if (enq && !full_w && (!deq || empty_w)) begin
                    do_ins  = 1'b1;
                    count_d = ins_idx;
                    idx_d   = ins_idx;
                    state_d = empty_w ? IDLE : SIFT_UP;
                end else if (deq && !empty_w) begin
                    idx_d = ROOT;
                    if (enq) begin
                        do_rep  = 1'b1;
                        state_d = (count_q > ROOT) ? SIFT_DOWN : IDLE;
                    end else begin
                        do_rem  = 1'b1;
                        count_d = count_q - ROOT;
                        state_d = (count_q > idx_t'(2)) ? SIFT_DOWN : IDLE;
                    end
                end
            end
            SIFT_UP: begin
                state_d = IDLE;
                if ((idx_q != ROOT) && cand_better) begin
                    do_swap = 1'b1;
                    idx_d   = parent_idx;
                    state_d = (parent_idx == ROOT) ? IDLE : SIFT_UP;
                end
            end
            SIFT_DOWN: begin
                state_d = IDLE;
                if (left_ok && cand_better) begin
                    do_swap = 1'b1;
                    idx_d   = child_idx;
                    state_d = grand_ok ? SIFT_DOWN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, which the swap below depends on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= ROOT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: heap storage is deliberately not reset; slots above count are
    // never observed, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_ins) begin
            heap_key_q[ins_idx] <= kvi_key;
            heap_val_q[ins_idx] <= kvi_val;
        end else if (do_rep) begin
            heap_key_q[ROOT] <= kvi_key;
            heap_val_q[ROOT] <= kvi_val;
        end else if (do_rem) begin
            heap_key_q[ROOT] <= heap_key_q[count_q];
            heap_val_q[ROOT] <= heap_val_q[count_q];
        end else if (do_swap) begin
            heap_key_q[cand_idx] <= heap_key_q[node_idx];
            heap_val_q[cand_idx] <= heap_val_q[node_idx];
            heap_key_q[node_idx] <= heap_key_q[cand_idx];
            heap_val_q[node_idx] <= heap_val_q[cand_idx];
        end
    end

    assign kvo_key   = heap_key_q[ROOT];
    assign kvo_val   = heap_val_q[ROOT];
    assign busy      = (state_q != IDLE);
    assign kvo_valid = !empty_w && !busy;
    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = count_q;

endmodule

// File: tb/tb_heap_pq_param.sv
// Bench for heap_pq_param: one min-queue and one max-queue instance, checked
// with a vector table, hand sequences and random traffic against a queue model.
module tb_heap_pq_param;

    localparam int DEPTH  = 7;
    localparam int MAXB   = 2;
    localparam int TMO    = 20;

    logic       clk = 1'b0;
    logic       rst_s       [2];
    logic       enq_s       [2];
    logic       deq_s       [2];
    logic [7:0] key_s       [2];
    logic [7:0] val_s       [2];
    logic [7:0] kvo_key_s   [2];
    logic [7:0] kvo_val_s   [2];
    logic       kvo_valid_s [2];
    logic       full_s      [2];
    logic       empty_s     [2];
    logic       busy_s      [2];
    logic [2:0] count_s     [2];

    int tests = 0;
    int fails = 0;
    int mk[$];

    always #5 clk = ~clk;

    heap_pq_param #(.KEY_W(8), .VAL_W(8), .LEVELS(3), .MAX_FIRST(0)) u_min (
        .clk(clk), .rst(rst_s[0]), .enq(enq_s[0]), .deq(deq_s[0]),
        .kvi_key(key_s[0]), .kvi_val(val_s[0]),
        .kvo_key(kvo_key_s[0]), .kvo_val(kvo_val_s[0]), .kvo_valid(kvo_valid_s[0]),
        .full(full_s[0]), .empty(empty_s[0]), .busy(busy_s[0]), .count(count_s[0])
    );

    heap_pq_param #(.KEY_W(8), .VAL_W(8), .LEVELS(3), .MAX_FIRST(1)) u_max (
        .clk(clk), .rst(rst_s[1]), .enq(enq_s[1]), .deq(deq_s[1]),
        .kvi_key(key_s[1]), .kvi_val(val_s[1]),
        .kvo_key(kvo_key_s[1]), .kvo_val(kvo_val_s[1]), .kvo_valid(kvo_valid_s[1]),
        .full(full_s[1]), .empty(empty_s[1]), .busy(busy_s[1]), .count(count_s[1])
    );

    typedef struct {
        logic       e;
        logic       d;
        logic [7:0] k;
        int         exp_cnt;
        int         exp_top;   // -1: queue empty, top not checked
    } vec_t;

    vec_t vecs [17];

    function automatic logic [7:0] val_of(input logic [7:0] k);
        return k ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input int u, input string tag, input int exp_cnt, input int exp_top);
        check({tag, "_count"}, 32'(count_s[u]), 32'(exp_cnt));
        check({tag, "_empty"}, 32'(empty_s[u]), 32'(exp_cnt == 0));
        check({tag, "_full"},  32'(full_s[u]),  32'(exp_cnt == DEPTH));
        check({tag, "_busy"},  32'(busy_s[u]),  32'd0);
        check({tag, "_valid"}, 32'(kvo_valid_s[u]), 32'(exp_cnt > 0));
        if (exp_top >= 0) begin
            check({tag, "_top"}, 32'(kvo_key_s[u]), 32'(exp_top));
            check({tag, "_val"}, 32'(kvo_val_s[u]), 32'(val_of(8'(exp_top))));
        end
    endtask

    task automatic apply_reset(input int u);
        @(negedge clk);
        rst_s[u] = 1'b1;
        @(negedge clk);
        rst_s[u] = 1'b0;
    endtask

    // One-cycle request, then wait (bounded) for the queue to go idle.
    task automatic do_req(input int u, input logic e, input logic d, input logic [7:0] k,
                          output int nb);
        @(negedge clk);
        enq_s[u] = e;
        deq_s[u] = d;
        key_s[u] = k;
        val_s[u] = val_of(k);
        @(negedge clk);
        enq_s[u] = 1'b0;
        deq_s[u] = 1'b0;
        nb = 0;
        while (busy_s[u] === 1'b1 && nb < TMO) begin
            @(negedge clk);
            nb++;
        end
    endtask

    function automatic int best_pos(input int maxf);
        int b = 0;
        for (int i = 1; i < mk.size(); i++)
            if ((maxf != 0) ? (mk[i] > mk[b]) : (mk[i] < mk[b])) b = i;
        return b;
    endfunction

    function automatic void model_apply(input int maxf, input logic e, input logic d, input int k);
        int n = mk.size();
        if (e && (!d || n == 0)) begin
            if (n < DEPTH) mk.push_back(k);
        end else if (d && n > 0) begin
            mk.delete(best_pos(maxf));
            if (e) mk.push_back(k);
        end
    endfunction

    initial begin
        int nb;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; enq_s[u] = 1'b0; deq_s[u] = 1'b0;
            key_s[u] = '0;   val_s[u] = '0;
        end

        vecs[0]  = '{1'b1, 1'b0, 8'd5,  1, 5};
        vecs[1]  = '{1'b1, 1'b0, 8'd3,  2, 3};
        vecs[2]  = '{1'b1, 1'b0, 8'd8,  3, 3};
        vecs[3]  = '{1'b1, 1'b0, 8'd1,  4, 1};
        vecs[4]  = '{1'b0, 1'b1, 8'd0,  3, 3};
        vecs[5]  = '{1'b0, 1'b1, 8'd0,  2, 5};
        vecs[6]  = '{1'b0, 1'b1, 8'd0,  1, 8};
        vecs[7]  = '{1'b0, 1'b1, 8'd0,  0, -1};
        vecs[8]  = '{1'b1, 1'b0, 8'd70, 1, 70};
        vecs[9]  = '{1'b1, 1'b0, 8'd60, 2, 60};
        vecs[10] = '{1'b1, 1'b0, 8'd50, 3, 50};
        vecs[11] = '{1'b1, 1'b0, 8'd40, 4, 40};
        vecs[12] = '{1'b1, 1'b0, 8'd30, 5, 30};
        vecs[13] = '{1'b1, 1'b0, 8'd20, 6, 20};
        vecs[14] = '{1'b1, 1'b0, 8'd10, 7, 10};
        vecs[15] = '{1'b1, 1'b0, 8'd0,  7, 10};
        vecs[16] = '{1'b0, 1'b1, 8'd0,  6, 20};

        repeat (2) @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);
        check_state(0, "rst_min", 0, -1);
        check_state(1, "rst_max", 0, -1);

        // Vector table on the min-queue; the last row is applied only after
        // the replace sequence, which needs the full queue.
        for (int i = 0; i < 16; i++) begin
            do_req(0, vecs[i].e, vecs[i].d, vecs[i].k, nb);
            check($sformatf("vec%0d_lat", i), 32'(nb <= MAXB), 32'd1);
            check_state(0, $sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_top);
        end

        // Replace while full: 99 goes to the root and sinks to a leaf.
        do_req(0, 1'b1, 1'b1, 8'd99, nb);
        check("rep_lat", 32'(nb <= MAXB), 32'd1);
        check("rep_did_sift", 32'(nb > 0), 32'd1);
        check_state(0, "rep", 7, 20);
        do_req(0, vecs[16].e, vecs[16].d, vecs[16].k, nb);
        check_state(0, "vec16", vecs[16].exp_cnt, 30);

        // Max-queue with duplicate keys.
        apply_reset(1);
        do_req(1, 1'b1, 1'b0, 8'd4, nb);
        do_req(1, 1'b1, 1'b0, 8'd9, nb);
        do_req(1, 1'b1, 1'b0, 8'd9, nb);
        do_req(1, 1'b1, 1'b0, 8'd2, nb);
        check_state(1, "max_ins", 4, 9);
        do_req(1, 1'b0, 1'b1, 8'd0, nb);
        check_state(1, "max_rm1", 3, 9);
        do_req(1, 1'b0, 1'b1, 8'd0, nb);
        check_state(1, "max_rm2", 2, 4);

        // Remove on empty, and an insert dropped while the queue is busy.
        apply_reset(0);
        do_req(0, 1'b0, 1'b1, 8'd0, nb);
        check_state(0, "deq_empty", 0, -1);
        do_req(0, 1'b1, 1'b0, 8'd50, nb);
        do_req(0, 1'b1, 1'b0, 8'd60, nb);
        do_req(0, 1'b1, 1'b0, 8'd70, nb);
        @(negedge clk);
        enq_s[0] = 1'b1; key_s[0] = 8'd10; val_s[0] = val_of(8'd10);
        @(negedge clk);
        check("drop_busy", 32'(busy_s[0]), 32'd1);
        key_s[0] = 8'd1; val_s[0] = val_of(8'd1);
        @(negedge clk);
        enq_s[0] = 1'b0;
        nb = 0;
        while (busy_s[0] === 1'b1 && nb < TMO) begin
            @(negedge clk);
            nb++;
        end
        check_state(0, "drop", 4, 10);

        // Reset asserted in the middle of a sift-down.
        @(negedge clk);
        deq_s[0] = 1'b1;
        @(negedge clk);
        deq_s[0] = 1'b0;
        check("rst_mid_busy", 32'(busy_s[0]), 32'd1);
        rst_s[0] = 1'b1;
        @(negedge clk);
        check_state(0, "rst_mid", 0, -1);
        rst_s[0] = 1'b0;
        do_req(0, 1'b1, 1'b0, 8'd6, nb);
        check_state(0, "after_rst", 1, 6);

        // Random traffic against the queue model, both orderings.
        for (int u = 0; u < 2; u++) begin
            apply_reset(u);
            mk.delete();
            for (int n = 0; n < 150; n++) begin
                logic       e, d;
                logic [7:0] k;
                e = ($urandom_range(0, 99) < 60);
                d = ($urandom_range(0, 99) < 45);
                k = 8'($urandom_range(0, 31));
                do_req(u, e, d, k, nb);
                model_apply(u, e, d, int'(k));
                check($sformatf("rnd%0d_%0d_lat", u, n), 32'(nb <= MAXB), 32'd1);
                check_state(u, $sformatf("rnd%0d_%0d", u, n), mk.size(),
                            (mk.size() > 0) ? mk[best_pos(u)] : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/heap_pq_param.md
HEAP_PQ_PARAM -- requirements
Module: heap_pq_param

Interface
REQ-001 SHALL have parameter KEY_W, default 8: key width in bits.
REQ-002 SHALL have parameter VAL_W, default 8: value width in bits.
REQ-003 SHALL have parameter LEVELS, default 3: heap depth; capacity DEPTH = 2**LEVELS-1; legal range 2..10.
REQ-004 SHALL have parameter MAX_FIRST, default 0: 0 = min-queue (smallest key at top); 1 = max-queue.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enq, input, 1: insert request.
REQ-008 SHALL have port deq, input, 1: remove-top request; enq and deq in the same cycle form a replace request.
REQ-009 SHALL have port kvi_key, input, KEY_W: key of the item to insert.
REQ-010 SHALL have port kvi_val, input, VAL_W: value of the item to insert.
REQ-011 SHALL have port kvo_key, output, KEY_W: key of the top item.
REQ-012 SHALL have port kvo_val, output, VAL_W: value of the top item.
REQ-013 SHALL have port kvo_valid, output, 1: high when empty=0 and busy=0.
REQ-014 SHALL have port full, output, 1: count==DEPTH.
REQ-015 SHALL have port empty, output, 1: count==0.
REQ-016 SHALL have port busy, output, 1: a sift is in progress and requests are ignored.
REQ-017 SHALL have port count, output, LEVELS: number of stored items.

Function
REQ-018 SHALL store items in a 1-indexed array heap[1:DEPTH]; children of node i are 2i and 2i+1.
REQ-019 SHALL drive kvo_key/kvo_val from heap[1]; contents are don't-care when kvo_valid=0.
REQ-020 SHALL ignore every request while busy=1, and SHALL give no acceptance indication; the requester holds or re-issues.
REQ-021 SHALL accept an insert when enq=1, deq=0, busy=0 and full=0: write to heap[count+1], increment count, enter SIFT_UP at that index.
REQ-022 SHALL accept a remove when deq=1, enq=0, busy=0 and empty=0: move heap[count] to heap[1], decrement count, enter SIFT_DOWN at index 1; if the queue becomes empty, go to IDLE.
REQ-023 SHALL accept a replace when enq=1, deq=1, busy=0 and empty=0, including when full=1: write kvi to heap[1], leave count unchanged, enter SIFT_DOWN at index 1.
REQ-024 SHALL ignore enq when full=1 and deq=0, ignore deq when empty=1, and treat enq+deq with empty=1 as an insert.
REQ-025 SHALL use FSM states IDLE, SIFT_UP and SIFT_DOWN, with busy=1 exactly in SIFT_UP and SIFT_DOWN.
REQ-026 SHALL, in SIFT_UP, perform one compare/swap per cycle: if node i is strictly better than its parent, swap and set i to parent; otherwise, or when i==1, return to IDLE.
REQ-027 SHALL, in SIFT_DOWN, select the better child per cycle (left wins ties; nodes above count do not exist): if the child is strictly better than node i, swap and descend; otherwise, or with no children, return to IDLE.
REQ-028 SHALL define "better" as a strictly smaller key when MAX_FIRST=0 and a strictly larger key when MAX_FIRST=1; equal keys never swap.
REQ-029 SHALL keep busy for at most LEVELS-1 cycles after the accepting cycle; kvo_valid returns to 1 in the first IDLE cycle.
REQ-030 SHALL compute count arithmetic at LEVELS bits without overflow; DEPTH fits exactly.

Reset
REQ-031 SHALL, on rst=1, set count=0, state=IDLE, busy=0, empty=1, full=0, kvo_valid=0, and SHALL leave heap contents unreset.
REQ-032 SHALL give rst priority over all requests, and SHALL abandon any sift in progress when reset is asserted mid-operation.

Structure
REQ-033 SHALL place the state enum (IDLE, SIFT_UP, SIFT_DOWN) in pq_pkg; key/value types derive locally from KEY_W/VAL_W.
REQ-034 SHALL implement the better-than comparison, parameterised by KEY_W and MAX_FIRST, as one sub-module heap_cmp, instantiated twice: child-vs-child and candidate-vs-node.

Verification (LEVELS=3, KEY_W=8)
REQ-035 SHALL, with MAX_FIRST=0, insert keys 5,3,8,1 (waiting for !busy after each) -> top key 1, count=4; four removes yield tops 3,5,8, then empty=1.
REQ-036 SHALL insert 7 items 70..10 descending -> full=1, count=7; a further enq with key 0 is ignored, count stays 7 and top stays 10.
REQ-037 SHALL, when full with top 10, replace with key 99 -> count stays 7, busy for at most 2 cycles, then top 20.
REQ-038 SHALL, with MAX_FIRST=1, insert 4,9,9,2 -> top 9; one remove -> top 9, count=3; next remove -> top 4.
REQ-039 SHALL, when deq is asserted while empty, keep count=0 and busy=0; enq during busy is dropped, and count changes only on accepted requests.
REQ-040 SHALL, when rst is asserted during SIFT_DOWN, set count=0, busy=0 and empty=1 the next cycle; then insert 6 -> top 6.
